fifo_rd_stream: RTL and testbench

//  Read-side adapter for fifo_sync: drains the FIFO and presents the words as a valid/ready stream.
//  - Issues fifo_rd_en and tracks the FIFO's fixed read latency (1 or 2 cycles).
//  - Holds returned words in a small skid buffer, so a stalled consumer never loses data.
//  - Sits between fifo_sync and any stream consumer, such as a UART TX or a display driver.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_rd_skid.sv | 60 ++++++
 rtl/fifo_rd_stream.sv | 103 ++++++++++
 tb/tb_fifo_rd_stream.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_sync read-side stream adapter:
// FSM encoding, fifo_sync read-latency constants and a constant clog2 helper.
package fifo_pkg;

  typedef enum logic {
    ST_WAIT_RDY = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  localparam int FIFO_RD_LAT_NOREG = 1;
  localparam int FIFO_RD_LAT_REG   = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Small register FIFO that absorbs words returned by fifo_sync while the
// consumer stalls; the head word is presented from a register.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int  FIFO_WIDTH = 8,
  parameter int  BUF_DEPTH  = 3,
  localparam int CNT_W      = clog2(BUF_DEPTH + 1),
  localparam int PTR_W      = (BUF_DEPTH > 1) ? clog2(BUF_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [FIFO_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count
);

  logic [FIFO_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]      remain, count_nxt;
  logic [FIFO_WIDTH-1:0] head_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Next head: the entry after the pop if one remains, else a word landing now.
  always_comb begin
    rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
    remain     = pop ? count - CNT_W'(1) : count;
    count_nxt  = push ? remain + CNT_W'(1) : remain;
    head_nxt   = head;
    if (remain != '0) begin
      head_nxt = mem[rd_ptr_nxt];
    end else if (push) begin
      head_nxt = push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= push ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains fifo_sync and presents its words as a valid/ready stream.
// Optional FIFO_RD_STREAM_STATS_EN adds saturating transfer/stall counters.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 8,
  parameter int RD_LATENCY = FIFO_RD_LAT_NOREG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_ready,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stalls
`endif
);

  localparam int BUF_DEPTH = RD_LATENCY + 2;
  localparam int CNT_W     = clog2(BUF_DEPTH + 1);

  state_t                state, state_nxt;
  logic [RD_LATENCY-1:0] rd_vld_p, rd_vld_nxt;
  logic [CNT_W-1:0]      buf_count, inflight;
  logic                  pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(rd_vld_p[i]);
  end

  // Credit covers both landed and in-flight words, so the buffer cannot overflow.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      ST_WAIT_RDY: begin
        if (fifo_ready) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!fifo_ready) state_nxt = ST_WAIT_RDY;
        fifo_rd_en = fifo_ready && !fifo_empty &&
                     ((buf_count + inflight) < CNT_W'(BUF_DEPTH));
      end
      default: state_nxt = ST_WAIT_RDY;
    endcase
  end

  always_comb begin
    rd_vld_nxt    = rd_vld_p << 1;
    rd_vld_nxt[0] = fifo_rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_WAIT_RDY;
      rd_vld_p <= '0;
    end else begin
      state    <= state_nxt;
      rd_vld_p <= rd_vld_nxt;
    end
  end

  // Read-return stage boundary: the pipe tail marks fifo_rd_data as valid.
  fifo_rd_skid #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_vld_p[RD_LATENCY-1]),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head      (m_data),
    .count     (buf_count)
  );

  assign m_valid = (buf_count != '0);
  assign pop     = m_valid && m_ready;

`ifdef FIFO_RD_STREAM_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (pop) stat_words <= sat_inc(stat_words);
      if (m_valid && !m_ready) stat_stalls <= sat_inc(stat_stalls);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: two adapters (RD_LATENCY 1 and 2) each paired with a
// fifo_sync model; both see the same writes, fifo_ready and m_ready.
module tb_fifo_rd_stream;

  logic            clk = 1'b0;
  logic            rst_n, fifo_ready, m_ready, wr_en;
  logic [7:0]      wr_data;
  logic [1:0]      fifo_empty, fifo_rd_en, m_valid;
  logic [1:0][7:0] fifo_rd_data, m_data;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [1:0][31:0] stat_words, stat_stalls;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]      fmem [1024];
  int unsigned     wp = 0;
  int unsigned     rp [2] = '{0, 0};
  logic [1:0][7:0] d1, d2;

  logic [7:0]      got      [2][$];
  int              xfer_cyc [2][$];
  int              rd_cyc   [2][$];
  int              vld_rise [2][$];
  int              rd_empty_viol [2] = '{0, 0};
  int              hold_viol     [2] = '{0, 0};
  logic [1:0]      prev_vld = '0;
  logic [1:0]      prev_stall = '0;
  logic [1:0][7:0] prev_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_rd_stream #(.FIFO_WIDTH(8), .RD_LATENCY(1)) u_dut_lat1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_ready   (fifo_ready),
    .fifo_empty   (fifo_empty[0]),
    .fifo_rd_en   (fifo_rd_en[0]),
    .fifo_rd_data (fifo_rd_data[0]),
    .m_valid      (m_valid[0]),
    .m_data       (m_data[0]),
    .m_ready      (m_ready)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .stat_words   (stat_words[0]),
    .stat_stalls  (stat_stalls[0])
`endif
  );

  fifo_rd_stream #(.FIFO_WIDTH(8), .RD_LATENCY(2)) u_dut_lat2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_ready   (fifo_ready),
    .fifo_empty   (fifo_empty[1]),
    .fifo_rd_en   (fifo_rd_en[1]),
    .fifo_rd_data (fifo_rd_data[1]),
    .m_valid      (m_valid[1]),
    .m_data       (m_data[1]),
    .m_ready      (m_ready)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .stat_words   (stat_words[1]),
    .stat_stalls  (stat_stalls[1])
`endif
  );

  // fifo_sync model: shared storage, one read port per adapter (DO_REG=0 / DO_REG=1).
  always @(posedge clk) begin
    if (wr_en) begin
      fmem[wp % 1024] <= wr_data;
      wp <= wp + 1;
    end
    for (int k = 0; k < 2; k++) begin
      if (fifo_rd_en[k]) begin
        d1[k] <= fmem[rp[k] % 1024];
        rp[k] <= rp[k] + 1;
      end
      d2[k] <= d1[k];
    end
  end

  assign fifo_empty[0]   = (wp == rp[0]);
  assign fifo_empty[1]   = (wp == rp[1]);
  assign fifo_rd_data[0] = d1[0];
  assign fifo_rd_data[1] = d2[1];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        if (fifo_rd_en[k]) begin
          rd_cyc[k].push_back(cyc);
          if (fifo_empty[k]) rd_empty_viol[k]++;
        end
        if (m_valid[k] && m_ready) begin
          got[k].push_back(m_data[k]);
          xfer_cyc[k].push_back(cyc);
        end
        if (m_valid[k] && !prev_vld[k]) vld_rise[k].push_back(cyc);
        if (prev_stall[k] && (!m_valid[k] || m_data[k] != prev_data[k])) hold_viol[k]++;
      end
      prev_vld[k]   = rst_n && m_valid[k];
      prev_stall[k] = rst_n && m_valid[k] && !m_ready;
      prev_data[k]  = m_data[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_got(input int need0, input int need1, input int budget);
    for (int i = 0; i < budget && (got[0].size() < need0 || got[1].size() < need1); i++) tick();
  endtask

  function automatic logic [31:0] got_at(input int k, input int i);
    return (i < got[k].size()) ? 32'(got[k][i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic check_seq(input string tag, input int k, input int from,
                           input logic [7:0] first, input int n);
    int bad;
    bad = 0;
    check($sformatf("%s_count_lat%0d", tag, k + 1), 32'(got[k].size() - from), 32'(n));
    for (int i = 0; i < n; i++)
      if (got_at(k, from + i) !== 32'(first + 8'(i))) bad++;
    check($sformatf("%s_order_lat%0d", tag, k + 1), 32'(bad), 32'd0);
  endtask

  initial begin
    int base [2];
    int nrd  [2];
    int bad, w, st, gap, lat;

    rst_n = 1'b0; fifo_ready = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    tick(); tick();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst_n = 1'b1;

    // 1: a word sits in the FIFO but fifo_ready stays low
    write_word(8'hA5);
    bad = 0;
    repeat (6) begin
      tick();
      if (fifo_rd_en != 2'b00 || m_valid != 2'b00 || m_data != 16'h0000) bad++;
    end
    check("t1_idle_outputs", 32'(bad), 32'd0);
    check("t1_no_reads", 32'(rd_cyc[0].size() + rd_cyc[1].size()), 32'd0);

    // 2: short burst, latency from first read to first valid
    fifo_ready = 1'b1;
    m_ready    = 1'b1;
    write_word(8'h3C);
    write_word(8'h7E);
    wait_got(3, 3, 40);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t2_count_lat%0d", k + 1), 32'(got[k].size()), 32'd3);
      check($sformatf("t2_w0_lat%0d", k + 1), got_at(k, 0), 32'hA5);
      check($sformatf("t2_w1_lat%0d", k + 1), got_at(k, 1), 32'h3C);
      check($sformatf("t2_w2_lat%0d", k + 1), got_at(k, 2), 32'h7E);
      lat = (rd_cyc[k].size() > 0 && vld_rise[k].size() > 0) ? vld_rise[k][0] - rd_cyc[k][0] : -1;
      check($sformatf("t2_latency_lat%0d", k + 1), 32'(lat), 32'(k + 2));
    end

    // 3: consumer stalled while 16 words are written
    m_ready = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      base[k] = got[k].size();
      nrd[k]  = rd_cyc[k].size();
    end
    for (int i = 0; i < 16; i++) write_word(8'(i));
    repeat (8) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t3_reads_lat%0d", k + 1), 32'(rd_cyc[k].size() - nrd[k]), 32'(k + 3));
      check($sformatf("t3_rd_en_low_lat%0d", k + 1), 32'(fifo_rd_en[k]), 32'd0);
      check($sformatf("t3_valid_lat%0d", k + 1), 32'(m_valid[k]), 32'd1);
      check($sformatf("t3_head_lat%0d", k + 1), 32'(m_data[k]), 32'h00);
    end
    m_ready = 1'b1;
    wait_got(base[0] + 16, base[1] + 16, 60);
    for (int k = 0; k < 2; k++) begin
      check_seq("t3", k, base[k], 8'h00, 16);
      gap = (xfer_cyc[k].size() >= base[k] + 16) ? xfer_cyc[k][base[k] + 15] - xfer_cyc[k][base[k]] : -1;
      check($sformatf("t3_span_lat%0d", k + 1), 32'(gap), 32'd15);
    end

    // 4: 256 words under a randomly toggling consumer
    for (int k = 0; k < 2; k++) base[k] = got[k].size();
    w = 0;
    for (int c = 0; c < 4000 && (w < 256 || got[0].size() < base[0] + 256 ||
                                 got[1].size() < base[1] + 256); c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (w < 256) begin
        wr_en   = 1'b1;
        wr_data = 8'(w);
        w++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en   = 1'b0;
    m_ready = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 2; k++) check_seq("t4", k, base[k], 8'h00, 256);

    // 5: reset mid-operation with words buffered and in flight
    m_ready = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 2; k++) base[k] = got[k].size();
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h80 + 8'(i);
      if (i == 5) begin
        #2;
        check("t5_valid_before", 32'(m_valid), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t5_valid_async", 32'(m_valid), 32'd0);
      end
      tick();
    end
    wr_en = 1'b0;
    tick();
    #2;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    wait_got(base[0] + 5, base[1] + 4, 40);
    repeat (10) tick();
    for (int k = 0; k < 2; k++) check_seq("t5", k, base[k], 8'h83 + 8'(k), 5 - k);

    // 6: fresh reset, 10 words with a four-cycle stall
    rst_n = 1'b0;
    #1;
`ifdef FIFO_RD_STREAM_STATS_EN
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t6_words_rst_lat%0d", k + 1), stat_words[k], 32'd0);
      check($sformatf("t6_stalls_rst_lat%0d", k + 1), stat_stalls[k], 32'd0);
    end
`endif
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) base[k] = got[k].size();
    w  = 0;
    st = 0;
    for (int c = 0; c < 80 && (w < 10 || got[0].size() < base[0] + 10 ||
                               got[1].size() < base[1] + 10); c++) begin
      if (w < 10) begin
        wr_en   = 1'b1;
        wr_data = 8'h40 + 8'(w);
        w++;
      end else begin
        wr_en = 1'b0;
      end
      if (st == 0 && m_valid == 2'b11) begin
        m_ready = 1'b0;
        st = 1;
      end else if (st >= 1 && st < 4) begin
        st++;
      end else if (st == 4) begin
        m_ready = 1'b1;
        st = 5;
      end
      tick();
    end
    wr_en   = 1'b0;
    m_ready = 1'b1;
    repeat (4) tick();
    check("t6_stall_applied", 32'(st), 32'd5);
    for (int k = 0; k < 2; k++) begin
      check_seq("t6", k, base[k], 8'h40, 10);
`ifdef FIFO_RD_STREAM_STATS_EN
      check($sformatf("t6_stat_words_lat%0d", k + 1), stat_words[k], 32'd10);
      check($sformatf("t6_stat_stalls_lat%0d", k + 1), stat_stalls[k], 32'd4);
`endif
    end

    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd_while_empty_lat%0d", k + 1), 32'(rd_empty_viol[k]), 32'd0);
      check($sformatf("stall_hold_lat%0d", k + 1), 32'(hold_viol[k]), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
